stamp_arbiter: RTL and testbench



---
 rtl/stamp_pkg.sv | 18 +
 rtl/stamp_rr_pick.sv | 37 +++
 rtl/stamp_arbiter.sv | 135 +++++++++++++
 tb/tb_stamp_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stamp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stamp_pkg
//  Purpose  : Shared defaults and helpers for the stamp arbitration logic.
//  Revision : 1.0 - initial release
// ============================================================================
package stamp_pkg;

    localparam int TIMESTAMP_WIDTH_DEF = 64;
    localparam int NUM_PORTS_DEF       = 4;

    // Width of an index able to address n ports (never less than one bit).
    function automatic int port_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stamp_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : stamp_rr_pick
//  Purpose  : Combinational round-robin picker. Returns the first set bit of
//             'pend' searching upward from last+1, wrapping modulo NUM_PORTS.
//  Revision : 1.0 - initial release
// ============================================================================
module stamp_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0] pend,
    input  logic [IDX_WIDTH-1:0] last,
    output logic                 any,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    int w_dist;
    int w_best;

    // Pick the pending port with the smallest rotational distance from last+1.
    always_comb begin
        any       = |pend;
        grant_idx = '0;
        w_best    = NUM_PORTS;
        w_dist    = 0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_dist = (j - int'(last) - 1 + 2 * NUM_PORTS) % NUM_PORTS;
            if (pend[j] && (w_dist < w_best)) begin
                w_best    = w_dist;
                grant_idx = IDX_WIDTH'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stamp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : stamp_arbiter
//  Purpose  : Captures the free-running counter on each port's request pulse
//             and serialises the captured stamps round-robin onto a single
//             valid/ready stream tagged with the originating port.
//  Revision : 1.0 - initial release
// ============================================================================
module stamp_arbiter
    import stamp_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_DEF,
    parameter int NUM_PORTS       = NUM_PORTS_DEF,
    parameter int PORT_ID_WIDTH   = port_idx_width(NUM_PORTS_DEF)
) (
    input  logic                       axi_aclk,
    input  logic                       axi_reset,
    input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
    input  logic [NUM_PORTS-1:0]       req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TIMESTAMP_WIDTH-1:0] out_stamp,
    output logic [PORT_ID_WIDTH-1:0]   out_port,
    output logic [NUM_PORTS-1:0]       overflow,
    input  logic [NUM_PORTS-1:0]       clear_overflow
);

    logic [TIMESTAMP_WIDTH-1:0] r_cap [NUM_PORTS];
    logic [NUM_PORTS-1:0]       r_pend;
    logic [NUM_PORTS-1:0]       r_overflow;
    logic                       r_out_valid;
    logic [TIMESTAMP_WIDTH-1:0] r_out_stamp;
    logic [PORT_ID_WIDTH-1:0]   r_out_port;
    logic [PORT_ID_WIDTH-1:0]   r_last;

    logic                       w_loadable;
    logic                       w_bypass;
    logic [NUM_PORTS-1:0]       w_pick;
    logic                       w_any;
    logic [PORT_ID_WIDTH-1:0]   w_grant_idx;
    logic                       w_grant;
    logic [NUM_PORTS-1:0]       w_grant_dec;
    logic [TIMESTAMP_WIDTH-1:0] w_cap_sel;
    logic [TIMESTAMP_WIDTH-1:0] w_next_stamp;

    // With nothing pending, fresh requests compete directly so a lone request
    // reaches the output on the same edge that would have captured it.
    always_comb begin
        w_loadable = !r_out_valid || out_ready;
        w_bypass   = ~|r_pend;
        w_pick     = w_bypass ? req : r_pend;
    end

    stamp_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (PORT_ID_WIDTH)
    ) u_pick (
        .pend      (w_pick),
        .last      (r_last),
        .any       (w_any),
        .grant_idx (w_grant_idx)
    );

    // Decode the grant and select the stamp that goes to the output register.
    always_comb begin
        w_grant     = w_loadable && w_any;
        w_grant_dec = '0;
        w_cap_sel   = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_grant_dec[j] = w_grant && (w_grant_idx == PORT_ID_WIDTH'(j));
            if (w_grant_dec[j]) begin
                w_cap_sel = r_cap[j];
            end
        end
        w_next_stamp = w_bypass ? stamp_counter : w_cap_sel;
    end

    // Per-port capture, pending and sticky overflow state.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                r_cap[j] <= '0;
            end
            r_pend     <= '0;
            r_overflow <= '0;
        end else begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (req[j]) begin
                    if (!r_pend[j]) begin
                        // A bypass grant consumes the stamp immediately.
                        r_cap[j]  <= stamp_counter;
                        r_pend[j] <= !w_grant_dec[j];
                    end else if (w_grant_dec[j]) begin
                        // Old stamp leaves this edge; new one stays pending.
                        r_cap[j]  <= stamp_counter;
                    end
                end else if (w_grant_dec[j]) begin
                    r_pend[j] <= 1'b0;
                end

                if (req[j] && r_pend[j] && !w_grant_dec[j]) begin
                    r_overflow[j] <= 1'b1;
                end else if (clear_overflow[j]) begin
                    r_overflow[j] <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_out_valid <= 1'b0;
            r_out_stamp <= '0;
            r_out_port  <= '0;
            r_last      <= PORT_ID_WIDTH'(NUM_PORTS - 1);
        end else if (w_loadable) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_stamp <= w_next_stamp;
                r_out_port  <= w_grant_idx;
                r_last      <= w_grant_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_stamp = r_out_stamp;
    assign out_port  = r_out_port;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stamp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stamp_arbiter
//  Purpose  : Self-checking bench for stamp_arbiter with a beat scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stamp_arbiter;

    localparam int TW = 64;
    localparam int NP = 4;
    localparam int PW = 2;

    typedef struct {
        logic [PW-1:0] port;
        logic [TW-1:0] stamp;
    } beat_t;

    logic          clk = 1'b0;
    logic          axi_reset;
    logic [TW-1:0] stamp_counter;
    logic [NP-1:0] req;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_stamp;
    logic [PW-1:0] out_port;
    logic [NP-1:0] overflow;
    logic [NP-1:0] clear_overflow;

    beat_t sb[$];
    int    n_total = 0;
    int    n_pass  = 0;

    stamp_arbiter #(
        .TIMESTAMP_WIDTH (TW),
        .NUM_PORTS       (NP),
        .PORT_ID_WIDTH   (PW)
    ) dut (
        .axi_aclk       (clk),
        .axi_reset      (axi_reset),
        .stamp_counter  (stamp_counter),
        .req            (req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_stamp      (out_stamp),
        .out_port       (out_port),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted beat must match the next expected beat.
    always @(negedge clk) begin
        if (!axi_reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL beat_unexpected: got port %0d stamp %0d, expected no beat", out_port, out_stamp);
            end else begin
                beat_t e;
                e = sb.pop_front();
                if (out_port !== e.port || out_stamp !== e.stamp)
                    $display("FAIL beat: got port %0d stamp %0d, expected port %0d stamp %0d",
                             out_port, out_stamp, e.port, e.stamp);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        stamp_counter = stamp_counter + 1;
    endtask

    task automatic push(input int port, input longint stamp);
        beat_t b;
        b.port  = PW'(port);
        b.stamp = TW'(stamp);
        sb.push_back(b);
    endtask

    task automatic do_reset();
        axi_reset      = 1'b1;
        req            = '0;
        clear_overflow = '0;
        out_ready      = 1'b0;
        sb.delete();
        tick();
        tick();
        axi_reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (out_valid !== 1'b0 || out_stamp !== '0 || out_port !== '0 || overflow !== '0)
            $display("FAIL reset_values: got valid %0b stamp %0d port %0d ovf %b, expected all zero",
                     out_valid, out_stamp, out_port, overflow);
        else
            n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        out_ready     = 1'b1;
        stamp_counter = 100;
        repeat (5) tick();
        req = 4'b0100;
        push(2, 105);
        tick();
        req = '0;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL single_valid_t1: got %0b, expected 1", out_valid);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL single_valid_t2: got %0b, expected 0", out_valid);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL single_drain: got %0d left, expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready     = 1'b1;
        stamp_counter = 200;
        req           = 4'hF;
        for (int p = 0; p < NP; p++) push(p, 200);
        tick();
        req = '0;
        for (int k = 0; k < NP; k++) begin
            n_total++;
            if (out_valid !== 1'b1) $display("FAIL simul_valid_%0d: got %0b, expected 1", k, out_valid);
            else n_pass++;
            tick();
        end
        n_total++;
        if (out_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL simul_end: got valid %0b left %0d, expected 0 and 0", out_valid, sb.size());
        else
            n_pass++;
    endtask

    task automatic test_back_pressure();
        do_reset();
        stamp_counter = 300;
        req           = 4'hF;
        for (int p = 0; p < NP; p++) push(p, 300);
        tick();
        req = '0;
        for (int k = 0; k < 10; k++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_stamp !== TW'(300) || out_port !== 2'd0)
                $display("FAIL bp_hold_%0d: got valid %0b stamp %0d port %0d, expected 1 300 0",
                         k, out_valid, out_stamp, out_port);
            else
                n_pass++;
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        n_total++;
        if (sb.size() != 0) $display("FAIL bp_drain: got %0d left, expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        stamp_counter = 8;
        req = 4'b0001;
        push(0, 8);
        tick();
        req = '0;
        stamp_counter = 10;
        req = 4'b0010;
        push(1, 10);
        tick();
        req = '0;
        tick();
        req = 4'b0010;
        tick();
        req = '0;
        n_total++;
        if (overflow !== 4'b0010) $display("FAIL ovf_set: got %b, expected 0010", overflow);
        else n_pass++;
        clear_overflow = 4'b0010;
        tick();
        clear_overflow = '0;
        n_total++;
        if (overflow !== 4'b0000) $display("FAIL ovf_clear: got %b, expected 0000", overflow);
        else n_pass++;
        req            = 4'b0010;
        clear_overflow = 4'b0010;
        tick();
        req            = '0;
        clear_overflow = '0;
        n_total++;
        if (overflow !== 4'b0010) $display("FAIL ovf_set_wins: got %b, expected 0010", overflow);
        else n_pass++;
        clear_overflow = 4'b0010;
        tick();
        clear_overflow = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        n_total++;
        if (sb.size() != 0 || overflow !== 4'b0000)
            $display("FAIL ovf_drain: got left %0d ovf %b, expected 0 0000", sb.size(), overflow);
        else
            n_pass++;
    endtask

    task automatic test_rerequest();
        do_reset();
        stamp_counter = 50;
        req = 4'b0001;
        push(0, 50);
        tick();
        req = '0;
        stamp_counter = 52;
        req = 4'b1000;
        push(3, 52);
        tick();
        req = '0;
        stamp_counter = 55;
        out_ready = 1'b1;
        req = 4'b1000;
        push(3, 55);
        tick();
        req = '0;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        n_total++;
        if (sb.size() != 0 || overflow !== 4'b0000)
            $display("FAIL rereq: got left %0d ovf %b, expected 0 0000", sb.size(), overflow);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        stamp_counter = 70;
        req = 4'hF;
        tick();
        req = '0;
        tick();
        tick();
        axi_reset = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_stamp !== '0 || out_port !== '0 || overflow !== '0)
            $display("FAIL mid_reset: got valid %0b stamp %0d port %0d ovf %b, expected all zero",
                     out_valid, out_stamp, out_port, overflow);
        else
            n_pass++;
        tick();
        axi_reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL mid_reset_stale_%0d: got valid %0b, expected 0", k, out_valid);
            else n_pass++;
        end
    endtask

    initial begin
        axi_reset      = 1'b1;
        stamp_counter  = '0;
        req            = '0;
        clear_overflow = '0;
        out_ready      = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_back_pressure();
        test_overflow();
        test_rerequest();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
